// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, two write-back ports, issue port and status outputs.
interface reg_file_mp_if #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4,
  parameter int NREAD = 2
);
  logic [NREAD*RSIZE-1:0] RAddr;
  logic [NREAD-1:0]       Ren;
  logic [NREAD*DSIZE-1:0] RData;
  logic [NREAD-1:0]       Hazard;
  logic [RSIZE-1:0]       WAddrA;
  logic [DSIZE-1:0]       WDataA;
  logic                   WenA;
  logic [RSIZE-1:0]       WAddrB;
  logic [DSIZE-1:0]       WDataB;
  logic                   WenB;
  logic [RSIZE-1:0]       IssueAddr;
  logic                   IssueEn;
  logic [2**RSIZE-1:0]    Busy;
  logic                   WConflict;

  modport master (
    output RAddr, Ren, WAddrA, WDataA, WenA, WAddrB, WDataB, WenB, IssueAddr, IssueEn,
    input  RData, Hazard, Busy, WConflict
  );

  modport slave (
    input  RAddr, Ren, WAddrA, WDataA, WenA, WAddrB, WDataB, WenB, IssueAddr, IssueEn,
    output RData, Hazard, Busy, WConflict
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with dual write-back, busy scoreboard and registered reads.
// Optional macro RF_BYPASS_EN enables write-to-read forwarding and the Hazard same-cycle discount.
module reg_file_mp #(
  parameter int DSIZE    = 16,
  parameter int RSIZE    = 4,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          Clock,
  input  logic          Reset,
  reg_file_mp_if.slave  rf
);
  localparam int DEPTH = 2**RSIZE;
  localparam logic ZR  = (ZERO_REG != 0);

  logic [DEPTH-1:0][DSIZE-1:0] mem_q;
  logic [NREAD-1:0][DSIZE-1:0] rdata_q, rdata_d;
  logic [NREAD-1:0]            hazard_q, hazard_d;
  logic [DEPTH-1:0]            busy_q, busy_d;
  logic                        conflict_q, conflict_d;
  logic                        eff_a, eff_b;
  logic [RSIZE-1:0]            raddr [NREAD];

  always_comb begin
    eff_a      = rf.WenA && !(ZR && (rf.WAddrA == '0));
    eff_b      = rf.WenB && !(ZR && (rf.WAddrB == '0));
    conflict_d = eff_a && eff_b && (rf.WAddrA == rf.WAddrB);
  end

  // Issue is applied after the write clears so a same-cycle reissue stays pending.
  always_comb begin
    busy_d = busy_q;
    if (eff_a) busy_d[rf.WAddrA] = 1'b0;
    if (eff_b) busy_d[rf.WAddrB] = 1'b0;
    if (rf.IssueEn && !(ZR && (rf.IssueAddr == '0))) busy_d[rf.IssueAddr] = 1'b1;
    if (ZR) busy_d[0] = 1'b0;
  end

  always_comb begin
    for (int unsigned i = 0; i < NREAD; i++) begin
      raddr[i] = rf.RAddr[i*RSIZE +: RSIZE];
    end
  end

  always_comb begin
    rdata_d  = rdata_q;
    hazard_d = hazard_q;
    for (int unsigned i = 0; i < NREAD; i++) begin
      if (rf.Ren[i]) begin
`ifdef RF_BYPASS_EN
        if (ZR && (raddr[i] == '0))                rdata_d[i] = '0;
        else if (eff_b && (rf.WAddrB == raddr[i])) rdata_d[i] = rf.WDataB;
        else if (eff_a && (rf.WAddrA == raddr[i])) rdata_d[i] = rf.WDataA;
        else                                       rdata_d[i] = mem_q[raddr[i]];
        hazard_d[i] = busy_q[raddr[i]] &&
                      !((eff_a && (rf.WAddrA == raddr[i])) || (eff_b && (rf.WAddrB == raddr[i])));
`else
        if (ZR && (raddr[i] == '0)) rdata_d[i] = '0;
        else                        rdata_d[i] = mem_q[raddr[i]];
        hazard_d[i] = busy_q[raddr[i]];
`endif
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mem_q      <= '0;
      rdata_q    <= '0;
      hazard_q   <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      // B is assigned last so it wins a same-address dual write.
      if (eff_a) mem_q[rf.WAddrA] <= rf.WDataA;
      if (eff_b) mem_q[rf.WAddrB] <= rf.WDataB;
      rdata_q    <= rdata_d;
      hazard_q   <= hazard_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign rf.RData     = rdata_q;
  assign rf.Hazard    = hazard_q;
  assign rf.Busy      = busy_q;
  assign rf.WConflict = conflict_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed scoreboard bench for reg_file_mp (DSIZE=16, RSIZE=4, NREAD=2, ZERO_REG=1).
module tb_reg_file_mp;
  logic Clock;
  logic Reset;

  reg_file_mp_if #(.DSIZE(16), .RSIZE(4), .NREAD(2)) bus ();

  reg_file_mp #(.DSIZE(16), .RSIZE(4), .NREAD(2), .ZERO_REG(1)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .rf    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam int S_RD0 = 0, S_RD1 = 1, S_HZ0 = 2, S_HZ1 = 3, S_BUSY = 4, S_WC = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input int sel, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_RD0:   return bus.RData[15:0];
      S_RD1:   return bus.RData[31:16];
      S_HZ0:   return {15'b0, bus.Hazard[0]};
      S_HZ1:   return {15'b0, bus.Hazard[1]};
      S_BUSY:  return bus.Busy;
      default: return {15'b0, bus.WConflict};
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_assert++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    bus.Ren       = '0;
    bus.WenA      = 1'b0;
    bus.WenB      = 1'b0;
    bus.IssueEn   = 1'b0;
    bus.WAddrA    = '0;
    bus.WAddrB    = '0;
    bus.WDataA    = '0;
    bus.WDataB    = '0;
    bus.IssueAddr = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    drain();
    idle();
  endtask

  task automatic rd(input int port, input logic [3:0] a);
    bus.Ren[port] = 1'b1;
    bus.RAddr[port*4 +: 4] = a;
  endtask

  task automatic wa(input logic [3:0] a, input logic [15:0] d);
    bus.WenA = 1'b1; bus.WAddrA = a; bus.WDataA = d;
  endtask

  task automatic wb(input logic [3:0] a, input logic [15:0] d);
    bus.WenB = 1'b1; bus.WAddrB = a; bus.WDataB = d;
  endtask

  task automatic iss(input logic [3:0] a);
    bus.IssueEn = 1'b1; bus.IssueAddr = a;
  endtask

  initial begin
    Reset     = 1'b0;
    bus.RAddr = '0;
    idle();
    #2;
    push("reset_rdata0", S_RD0, 16'h0000);
    push("reset_rdata1", S_RD1, 16'h0000);
    push("reset_busy", S_BUSY, 16'h0000);
    push("reset_wconf", S_WC, 16'h0000);
    drain();
    @(negedge Clock);
    Reset = 1'b1;

    // write then read, then hold with Ren=0
    wa(4'd5, 16'hBEEF);
    push("wr_wconf0", S_WC, 16'h0000);
    tick();
    rd(0, 4'd5);
    push("rd_r5", S_RD0, 16'hBEEF);
    push("rd_r5_hz", S_HZ0, 16'h0000);
    tick();
    bus.RAddr[3:0] = 4'd3;
    push("hold_r5", S_RD0, 16'hBEEF);
    tick();

    // same-cycle write/read of R7
    wa(4'd7, 16'h00AA);
    rd(0, 4'd7);
`ifdef RF_BYPASS_EN
    push("bypass_r7", S_RD0, 16'h00AA);
`else
    push("nobypass_r7", S_RD0, 16'h0000);
`endif
    tick();
    rd(0, 4'd7);
    push("reread_r7", S_RD0, 16'h00AA);
    tick();
    bus.WAddrA = 4'd7; bus.WDataA = 16'h5555;
    rd(0, 4'd7);
    push("no_fwd_wen0", S_RD0, 16'h00AA);
    tick();

    // dual write to R2, B wins
    wa(4'd2, 16'h1111);
    wb(4'd2, 16'h2222);
    rd(1, 4'd2);
`ifdef RF_BYPASS_EN
    push("dual_fwd", S_RD1, 16'h2222);
`else
    push("dual_old", S_RD1, 16'h0000);
`endif
    push("dual_wconf1", S_WC, 16'h0001);
    tick();
    rd(1, 4'd2);
    push("dual_r2", S_RD1, 16'h2222);
    push("dual_wconf0", S_WC, 16'h0000);
    tick();

    // dual write to different addresses
    wa(4'd4, 16'h4444);
    wb(4'd6, 16'h6666);
    push("diff_wconf", S_WC, 16'h0000);
    tick();
    rd(0, 4'd4);
    rd(1, 4'd6);
    push("diff_r4", S_RD0, 16'h4444);
    push("diff_r6", S_RD1, 16'h6666);
    tick();

    // zero register
    wa(4'd0, 16'hFFFF);
    wb(4'd0, 16'hFFFF);
    iss(4'd0);
    push("zero_wconf", S_WC, 16'h0000);
    push("zero_busy", S_BUSY, 16'h0000);
    tick();
    rd(0, 4'd0);
    push("zero_read", S_RD0, 16'h0000);
    push("zero_busy2", S_BUSY, 16'h0000);
    tick();

    // scoreboard on R9
    iss(4'd9);
    push("issue_busy9", S_BUSY, 16'h0200);
    tick();
    rd(0, 4'd9);
    push("hz_r9", S_HZ0, 16'h0001);
    push("hz_r9_data", S_RD0, 16'h0000);
    tick();
    wb(4'd9, 16'h0042);
    rd(1, 4'd9);
`ifdef RF_BYPASS_EN
    push("wb_r9_fwd", S_RD1, 16'h0042);
    push("wb_r9_hz", S_HZ1, 16'h0000);
`else
    push("wb_r9_old", S_RD1, 16'h0000);
    push("wb_r9_hz", S_HZ1, 16'h0001);
`endif
    push("wb_r9_busy", S_BUSY, 16'h0000);
    tick();
    iss(4'd9);
    wa(4'd9, 16'h0099);
    rd(0, 4'd9);
    push("reissue_busy", S_BUSY, 16'h0200);
    push("reissue_hz", S_HZ0, 16'h0000);
`ifdef RF_BYPASS_EN
    push("reissue_data", S_RD0, 16'h0099);
`else
    push("reissue_data", S_RD0, 16'h0042);
`endif
    tick();

    // async reset with pending state
    wa(4'd3, 16'h1234);
    tick();
    rd(0, 4'd3);
    rd(1, 4'd9);
    iss(4'd11);
    push("pre_rst_r3", S_RD0, 16'h1234);
    push("pre_rst_hz1", S_HZ1, 16'h0001);
    push("pre_rst_busy", S_BUSY, 16'h0A00);
    tick();
    wa(4'd3, 16'h5555);
    #2;
    Reset = 1'b0;
    #1;
    push("arst_rdata0", S_RD0, 16'h0000);
    push("arst_rdata1", S_RD1, 16'h0000);
    push("arst_hz1", S_HZ1, 16'h0000);
    push("arst_busy", S_BUSY, 16'h0000);
    drain();
    @(posedge Clock);
    @(negedge Clock);
    idle();
    Reset = 1'b1;
    rd(0, 4'd3);
    push("post_rst_r3", S_RD0, 16'h0000);
    push("post_rst_busy", S_BUSY, 16'h0000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
